mips_bus_arbiter: RTL and testbench
===================================

# mips_bus_arbiter

Two-master arbiter sharing the single Avalon-style memory bus (address/read/write/byteenable/writedata/readdata/waitrequest) between the CPU instruction-fetch port (master 0) and data-access port (master 1). It sits between `mips_cpu_bus` internals and the external memory slave. It serialises transfers, holds the grant across slave wait states, and returns read data to the issuing master only.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byteenable width = DATA_W/8

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- m0_address / m1_address  in  ADDR_W  master address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  stall to master
- m0_readdata / m1_readdata  out  DATA_W  registered read data
- s_address  out  ADDR_W; s_read, s_write  out  1; s_byteenable  out  DATA_W/8; s_writedata  out  DATA_W  slave-side bus
- s_waitrequest  in  1; s_readdata  in  DATA_W  slave response
- grant  out  2  one-hot current owner (debug)

## Operation
- Request: mN_req = mN_read | mN_write. If both read and write are asserted, the write wins and the read is suppressed towards the slave.
- FSM states: IDLE, OWN0, OWN1 (registered). Grant is one-hot: IDLE=00, OWN0=01, OWN1=10.
- IDLE: if no requests, stay. If one request, go to that owner. If both request, go to the priority winner.
- OWNn: slave bus is driven from master n. The non-owner sees waitrequest=1.
- Completion cycle: mN_req=1 & s_waitrequest=0. On completion, the next state is decided by the priority rule using the current requests. The current owner may be re-granted back-to-back with no IDLE bubble.
- Owner drops its request before completion: this is an abort. Return to IDLE next cycle; no data is captured.
- mN_waitrequest = ~(state==OWNn & s_waitrequest==0). It is 1 in IDLE, so every transfer costs at least 2 cycles.
- Read data: on a read completion, s_readdata is captured into mN_readdata of the owner. It is held until that master's next read completion. The other master's register is unchanged.
- In IDLE, s_read, s_write, s_byteenable and s_writedata are 0. s_address = 0.

## Timing
- Reset (async): state=IDLE, grant=00, m0/m1_waitrequest=1, m0/m1_readdata=0, all s_* outputs=0.
- Arbitration latency: 1 cycle, from request in IDLE to OWNn.
- Slave bus outputs are combinational from the owner's inputs while in OWNn.
- mN_readdata is valid from the cycle after the completion edge.
- Reset asserted mid-transfer: the bus drops immediately and the transfer is lost. Masters restart after reset.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a tie, the master that did not complete the last transfer wins. The last-winner flag resets to master 1, so master 0 wins the first tie.
- Undefined: fixed priority, with master 1 (data) always winning ties. Master 0 can starve under continuous master-1 traffic.

## Structure
- Shared package `mips_bus_pkg` holds:
  - the state enum `arb_state_t` {IDLE, OWN0, OWN1}
  - the localparams for ADDR_W/DATA_W defaults
  - the reset-vector constant 32'hBFC00000, used by benches
- One sub-module, `mips_bus_mux`: a combinational 2:1 mux of the master bus fields, selected by the grant. It outputs zeros when grant=00.

## Test plan
- Single read: m0_read, address 0xBFC00000, s_waitrequest=0, slave data 0x00000003. Required: grant=01 at cycle 1; m0_readdata=0x00000003 at cycle 2; m1_readdata remains 0.
- Simultaneous reads from m0 and m1, fixed priority: required order OWN1 then OWN0, with no IDLE between them.
  - With ARB_ROUND_ROBIN_EN: first tie goes to m0; then, under continuous requests from both, grants alternate m1, m0, m1.
- Wait states: s_waitrequest high for 3 cycles during an m1 write of 0xDEADBEEF with byteenable 4'b1111.
  - Grant held 4 cycles; s_write asserted the whole time; m0 stalled throughout.
- Read+write both asserted by m1: s_write=1, s_read=0; m1_readdata unchanged.
- Abort: m0 drops read while s_waitrequest=1 → IDLE next cycle; m0_readdata unchanged.
- Async reset asserted mid-transfer of an m0 read: all outputs take reset values within the same cycle; the FSM restarts from IDLE after reset is released.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS bus arbiter and its benches.
package mips_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    // Boot address of the CPU; benches use it as a realistic first fetch.
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;

    // Selects the next owner from the live requests and the tie-break choice.
    function automatic arb_state_t arb_pick(input logic r0, input logic r1, input logic tie_m0);
        if (r0 && r1) return tie_m0 ? OWN0 : OWN1;
        if (r1)       return OWN1;
        if (r0)       return OWN0;
        return IDLE;
    endfunction

endpackage

// File: rtl/mips_bus_mux.sv
// Steers the granted master's bus fields onto the slave bus; zeros when idle.
module mips_bus_mux #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]          grant,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W/8-1:0] s_byteenable,
    output logic [DATA_W-1:0]   s_writedata
);

    // Grant-selected field mux; a simultaneous read+write goes out as a write only.
    always_comb begin
        s_address    = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_byteenable = '0;
        s_writedata  = '0;
        case (grant)
            2'b01: begin
                s_address    = m0_address;
                s_read       = m0_read & ~m0_write;
                s_write      = m0_write;
                s_byteenable = m0_byteenable;
                s_writedata  = m0_writedata;
            end
            2'b10: begin
                s_address    = m1_address;
                s_read       = m1_read & ~m1_write;
                s_write      = m1_write;
                s_byteenable = m1_byteenable;
                s_writedata  = m1_writedata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter (instruction fetch = m0, data = m1) for the shared memory bus.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to m1.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W/8-1:0] s_byteenable,
    output logic [DATA_W-1:0]   s_writedata,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    output logic [1:0]          grant
);

    arb_state_t state;
    arb_state_t next_state;
    logic       m0_req;
    logic       m1_req;
    logic       done0;
    logic       done1;
    logic       tie_m0;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;
    assign done0  = (state == OWN0) & m0_req & ~s_waitrequest;
    assign done1  = (state == OWN1) & m1_req & ~s_waitrequest;
    assign grant  = 2'(state);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_m1;

    // Remember which master completed last; the other one wins the next tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      last_m1 <= 1'b1;
        else if (done0) last_m1 <= 1'b0;
        else if (done1) last_m1 <= 1'b1;
    end

    assign tie_m0 = done1 | (~done0 & last_m1);
`else
    assign tie_m0 = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next owner: arbitrate from IDLE or on completion, abort to IDLE on a dropped request.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = arb_pick(m0_req, m1_req, tie_m0);
            OWN0: begin
                if (!m0_req)             next_state = IDLE;
                else if (!s_waitrequest) next_state = arb_pick(m0_req, m1_req, tie_m0);
            end
            OWN1: begin
                if (!m1_req)             next_state = IDLE;
                else if (!s_waitrequest) next_state = arb_pick(m0_req, m1_req, tie_m0);
            end
            default: next_state = IDLE;
        endcase
    end

    // Stall every master except the owner during a slave-ready cycle.
    always_comb begin
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        if (state == OWN0 && !s_waitrequest) m0_waitrequest = 1'b0;
        if (state == OWN1 && !s_waitrequest) m1_waitrequest = 1'b0;
    end

    // Capture read data for the completing owner only; writes leave it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_readdata <= '0;
            m1_readdata <= '0;
        end else begin
            if (done0 && m0_read && !m0_write) m0_readdata <= s_readdata;
            if (done1 && m1_read && !m1_write) m1_readdata <= s_readdata;
        end
    end

    mips_bus_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .grant         (grant),
        .m0_address    (m0_address),
        .m0_read       (m0_read),
        .m0_write      (m0_write),
        .m0_byteenable (m0_byteenable),
        .m0_writedata  (m0_writedata),
        .m1_address    (m1_address),
        .m1_read       (m1_read),
        .m1_write      (m1_write),
        .m1_byteenable (m1_byteenable),
        .m1_writedata  (m1_writedata),
        .s_address     (s_address),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_byteenable  (s_byteenable),
        .s_writedata   (s_writedata)
    );

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: vector table, directed sequences, random traffic.
module tb_mips_bus_arbiter;
    import mips_bus_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] m0_address, m1_address, s_address;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [BW-1:0] m0_byteenable, m1_byteenable, s_byteenable;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          s_read, s_write, s_waitrequest;
    logic [DW-1:0] s_readdata;
    logic [1:0]    grant;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: current owner (-1 none), last completer, per-master read data.
    int            own;
    int            last_w;
    logic [DW-1:0] rd_m [2];

    mips_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic r0, input logic r1, input int lastw);
        if (r0 && r1) return RR_MODE ? ((lastw == 0) ? 1 : 0) : 1;
        if (r1) return 1;
        if (r0) return 0;
        return -1;
    endfunction

    task automatic model_reset();
        own    = -1;
        last_w = 1;
        rd_m[0] = '0;
        rd_m[1] = '0;
    endtask

    // Compare every DUT output against what the model says for the current inputs.
    task automatic check_model();
        logic [1:0]    eg;
        logic [AW-1:0] ea;
        logic [BW-1:0] eb;
        logic [DW-1:0] ed;
        logic          er, ew;
        eg = 2'b00; ea = '0; eb = '0; ed = '0; er = 1'b0; ew = 1'b0;
        if (own == 0) begin
            eg = 2'b01; ea = m0_address; eb = m0_byteenable; ed = m0_writedata;
            er = m0_read & ~m0_write; ew = m0_write;
        end else if (own == 1) begin
            eg = 2'b10; ea = m1_address; eb = m1_byteenable; ed = m1_writedata;
            er = m1_read & ~m1_write; ew = m1_write;
        end
        chk("model_grant", 64'(grant), 64'(eg));
        chk("model_s_address", 64'(s_address), 64'(ea));
        chk("model_s_read", 64'(s_read), 64'(er));
        chk("model_s_write", 64'(s_write), 64'(ew));
        chk("model_s_byteenable", 64'(s_byteenable), 64'(eb));
        chk("model_s_writedata", 64'(s_writedata), 64'(ed));
        chk("model_m0_wait", 64'(m0_waitrequest), 64'(!(own == 0 && !s_waitrequest)));
        chk("model_m1_wait", 64'(m1_waitrequest), 64'(!(own == 1 && !s_waitrequest)));
        chk("model_m0_readdata", 64'(m0_readdata), 64'(rd_m[0]));
        chk("model_m1_readdata", 64'(m1_readdata), 64'(rd_m[1]));
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic r0, r1, ro, rdo, wro;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (own < 0) begin
            own = pick(r0, r1, last_w);
        end else begin
            ro  = (own == 0) ? r0 : r1;
            rdo = (own == 0) ? m0_read : m1_read;
            wro = (own == 0) ? m0_write : m1_write;
            if (!ro) begin
                own = -1;
            end else if (!s_waitrequest) begin
                if (rdo && !wro) rd_m[own] = s_readdata;
                last_w = own;
                own = pick(r0, r1, last_w);
            end
        end
    endtask

    // One cycle: check settled outputs, step the model, pass the edge, land 1 ns after it.
    task automatic tick();
        #1;
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_byteenable = '0; m0_writedata = '0;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_byteenable = '0; m1_writedata = '0;
        s_waitrequest = 1'b0; s_readdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic       r0, w0, r1, w1;
        logic [1:0] g;
        logic       sr, sw;
    } vec_t;

    vec_t          vecs [6];
    logic [1:0]    gseq [4];
    logic [7:0]    rnd;

    initial begin
        // Arbitration from IDLE: requests in, grant and slave strobes one edge later.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1};
        vecs[4] = RR_MODE ? '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0}
                          : '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0};
        vecs[5] = RR_MODE ? '{1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1}
                          : '{1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0};

        reset = 1'b1;
        clear_inputs();
        model_reset();
        #2;
        chk("reset_grant", 64'(grant), 64'(2'b00));
        chk("reset_m0_wait", 64'(m0_waitrequest), 64'(1'b1));
        chk("reset_m1_wait", 64'(m1_waitrequest), 64'(1'b1));
        chk("reset_m0_readdata", 64'(m0_readdata), 64'(0));
        chk("reset_m1_readdata", 64'(m1_readdata), 64'(0));
        chk("reset_s_read", 64'(s_read), 64'(0));
        chk("reset_s_address", 64'(s_address), 64'(0));

        for (int i = 0; i < 6; i++) begin
            do_reset();
            m0_address = 32'h100; m1_address = 32'h200;
            m0_read = vecs[i].r0; m0_write = vecs[i].w0;
            m1_read = vecs[i].r1; m1_write = vecs[i].w1;
            s_waitrequest = 1'b1;
            tick();
            chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].g));
            chk($sformatf("vec%0d_s_read", i), 64'(s_read), 64'(vecs[i].sr));
            chk($sformatf("vec%0d_s_write", i), 64'(s_write), 64'(vecs[i].sw));
        end

        // Single fetch from the reset vector.
        do_reset();
        m0_read = 1'b1; m0_address = RESET_VECTOR; m0_byteenable = 4'hF;
        s_waitrequest = 1'b0; s_readdata = 32'h0000_0003;
        tick();
        chk("single_grant", 64'(grant), 64'(2'b01));
        chk("single_s_address", 64'(s_address), 64'(32'hBFC0_0000));
        tick();
        chk("single_m0_readdata", 64'(m0_readdata), 64'(32'h0000_0003));
        chk("single_m1_readdata", 64'(m1_readdata), 64'(0));
        m0_read = 1'b0;
        tick();

        // Both masters reading continuously: fixed starves m0, round-robin alternates.
        do_reset();
        m0_read = 1'b1; m1_read = 1'b1; s_waitrequest = 1'b0;
        gseq = RR_MODE ? '{2'b01, 2'b10, 2'b01, 2'b10} : '{2'b10, 2'b10, 2'b10, 2'b10};
        for (int k = 0; k < 4; k++) begin
            s_readdata = 32'h1000 + 32'(k);
            tick();
            chk($sformatf("tie_seq%0d_grant", k), 64'(grant), 64'(gseq[k]));
        end

        // m1 write held through three slave wait states while m0 is stalled.
        do_reset();
        m1_write = 1'b1; m1_address = 32'h40; m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'hF;
        s_waitrequest = 1'b1;
        tick();
        m0_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_waitrequest = (k < 3);
            #1;
            chk($sformatf("wait%0d_grant", k), 64'(grant), 64'(2'b10));
            chk($sformatf("wait%0d_s_write", k), 64'(s_write), 64'(1'b1));
            chk($sformatf("wait%0d_s_writedata", k), 64'(s_writedata), 64'(32'hDEAD_BEEF));
            chk($sformatf("wait%0d_m0_wait", k), 64'(m0_waitrequest), 64'(1'b1));
            chk($sformatf("wait%0d_m1_wait", k), 64'(m1_waitrequest), 64'(k < 3));
            tick();
        end

        // m1 read then read+write: the combined request acts as a write only.
        do_reset();
        m1_read = 1'b1; s_waitrequest = 1'b0; s_readdata = 32'h0000_1234;
        tick();
        tick();
        chk("rw_pre_m1_readdata", 64'(m1_readdata), 64'(32'h0000_1234));
        m1_write = 1'b1; s_readdata = 32'hA5A5_A5A5;
        #1;
        chk("rw_s_write", 64'(s_write), 64'(1'b1));
        chk("rw_s_read", 64'(s_read), 64'(1'b0));
        tick();
        chk("rw_m1_readdata", 64'(m1_readdata), 64'(32'h0000_1234));
        m1_read = 1'b0; m1_write = 1'b0;
        tick();

        // Abort: m0 drops its read during a wait state.
        do_reset();
        m0_read = 1'b1; s_waitrequest = 1'b1; s_readdata = 32'h77;
        tick();
        chk("abort_grant_own", 64'(grant), 64'(2'b01));
        m0_read = 1'b0;
        tick();
        chk("abort_grant_idle", 64'(grant), 64'(2'b00));
        chk("abort_m0_readdata", 64'(m0_readdata), 64'(0));

        // Async reset in the middle of an m0 read.
        do_reset();
        m0_read = 1'b1; m0_address = 32'h80; s_waitrequest = 1'b0; s_readdata = 32'h99;
        tick();
        tick();
        chk("arst_pre_readdata", 64'(m0_readdata), 64'(32'h99));
        s_waitrequest = 1'b1;
        tick();
        #1;
        reset = 1'b1;
        #1;
        chk("arst_grant", 64'(grant), 64'(2'b00));
        chk("arst_s_read", 64'(s_read), 64'(0));
        chk("arst_s_address", 64'(s_address), 64'(0));
        chk("arst_m0_wait", 64'(m0_waitrequest), 64'(1'b1));
        chk("arst_m0_readdata", 64'(m0_readdata), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        tick();
        chk("arst_restart_grant", 64'(grant), 64'(2'b01));

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rnd = 8'($urandom_range(0, 7));
            m0_read = (rnd < 4); m0_write = (rnd >= 3 && rnd < 6);
            rnd = 8'($urandom_range(0, 7));
            m1_read = (rnd < 4); m1_write = (rnd >= 3 && rnd < 6);
            m0_address = $urandom; m1_address = $urandom;
            m0_writedata = $urandom; m1_writedata = $urandom;
            m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
            s_waitrequest = ($urandom_range(0, 2) == 0);
            s_readdata = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
